// File: rtl/gate_truth_table_scanner.sv
// rtl/gate_truth_table_scanner.sv - handshaked A/B stimulus scan and truth-table classifier for a two-input gate
module gate_truth_table_scanner #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       A,
   output logic       B,
   input  logic       Y,
   output logic       busy,
   output logic       done,
   output logic [3:0] truth_table,
   output logic [2:0] gate_id,
   output logic       gate_valid
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

   state_t     state_q, state_d;
   logic [1:0] ab_q, ab_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] shadow_q, shadow_d;
   logic [3:0] tt_q, tt_d;
   logic [2:0] id_q, id_d;
   logic       done_q, done_d;
   logic [3:0] full_tbl;

   // Decode a captured table (bit index = {A,B}) into a supported gate code.
   function automatic logic [2:0] classify(input logic [3:0] tbl);
      logic [2:0] id;
      case (tbl)
         4'b0011: id = 3'd1;
         4'b1000: id = 3'd2;
         4'b1110: id = 3'd3;
         4'b0111: id = 3'd4;
         4'b0001: id = 3'd5;
         4'b0110: id = 3'd6;
         4'b1001: id = 3'd7;
         default: id = 3'd0;
      endcase
      return id;
   endfunction

   // State and result registers; reset aborts any scan and discards the partial table.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         ab_q     <= 2'b00;
         cnt_q    <= 4'd0;
         shadow_q <= 4'd0;
         tt_q     <= 4'd0;
         id_q     <= 3'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ab_q     <= ab_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         tt_q     <= tt_d;
         id_q     <= id_d;
         done_q   <= done_d;
      end
   end

   // Next-state: step through 00,01,10,11, sampling Y on the last settle cycle of each combination.
   always_comb begin
      state_d  = state_q;
      ab_d     = ab_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      tt_d     = tt_q;
      id_d     = id_q;
      done_d   = 1'b0;
      full_tbl = shadow_q;
      full_tbl[ab_q] = Y;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = SCAN;
               ab_d     = 2'b00;
               cnt_d    = 4'd0;
               shadow_d = 4'd0;
            end
         end
         SCAN: begin
            if (cnt_q == SETTLE) begin
               shadow_d = full_tbl;
               cnt_d    = 4'd0;
               if (ab_q == 2'b11) begin
                  // Final bit goes straight into the published table on the same edge.
                  state_d = IDLE;
                  ab_d    = 2'b00;
                  done_d  = 1'b1;
                  tt_d    = full_tbl;
                  id_d    = classify(full_tbl);
               end else begin
                  ab_d = ab_q + 2'b01;
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign A           = ab_q[1];
   assign B           = ab_q[0];
   assign busy        = (state_q == SCAN);
   assign done        = done_q;
   assign truth_table = tt_q;
   assign gate_id     = id_q;
   assign gate_valid  = (id_q != 3'd0);

endmodule

// File: tb/tb_gate_truth_table_scanner.sv
// tb/tb_gate_truth_table_scanner.sv - self-checking bench for gate_truth_table_scanner
module tb_gate_truth_table_scanner;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start_v;
   logic [2:0] a_v, b_v, y_v, busy_v, done_v, valid_v;
   logic [3:0] tt_v [3];
   logic [2:0] id_v [3];
   logic [3:0] gtab [3];
   logic [3:0] prev_tt [3];
   logic [2:0] prev_id [3];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Gate models: each instance's Y is a lookup of its attached gate's table at {A,B}.
   assign y_v[0] = gtab[0][{a_v[0], b_v[0]}];
   assign y_v[1] = gtab[1][{a_v[1], b_v[1]}];
   assign y_v[2] = gtab[2][{a_v[2], b_v[2]}];

   gate_truth_table_scanner #(.SETTLE_CYCLES(1)) u0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .A(a_v[0]), .B(b_v[0]), .Y(y_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .truth_table(tt_v[0]), .gate_id(id_v[0]),
      .gate_valid(valid_v[0]));
   gate_truth_table_scanner #(.SETTLE_CYCLES(0)) u1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .A(a_v[1]), .B(b_v[1]), .Y(y_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .truth_table(tt_v[1]), .gate_id(id_v[1]),
      .gate_valid(valid_v[1]));
   gate_truth_table_scanner #(.SETTLE_CYCLES(2)) u2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .A(a_v[2]), .B(b_v[2]), .Y(y_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .truth_table(tt_v[2]), .gate_id(id_v[2]),
      .gate_valid(valid_v[2]));

   typedef struct {
      int         inst;
      int         s;
      int         lat;
      logic [3:0] gate;
      logic [3:0] etab;
      logic [2:0] eid;
      logic       ev;
      bit         poke;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset_state(input int inst, input string name);
      chk(name, {a_v[inst], b_v[inst], busy_v[inst], done_v[inst], tt_v[inst],
                 id_v[inst], valid_v[inst]}, 32'd0);
   endtask

   // Run one scan on an instance and check sequencing, latency and result.
   task automatic scan(input vec_t v);
      bit got = 0;
      int inst = v.inst;
      @(negedge clk);
      start_v[inst] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[inst] = 1'b0;
      chk("ab_after_accept", {30'd0, a_v[inst], b_v[inst]}, 32'd0);
      chk("busy_after_accept", {31'd0, busy_v[inst]}, 32'd1);
      for (int n = 1; n <= 100 && !got; n++) begin
         @(posedge clk);
         @(negedge clk);
         start_v[inst] = v.poke && (n == 2 || n == 3 || n == 7);
         if (done_v[inst] === 1'b1) begin
            got = 1;
            chk("latency", n, v.lat);
            chk("truth_table", {28'd0, tt_v[inst]}, {28'd0, v.etab});
            chk("gate_id", {29'd0, id_v[inst]}, {29'd0, v.eid});
            chk("gate_valid", {31'd0, valid_v[inst]}, {31'd0, v.ev});
            chk("busy_in_done", {31'd0, busy_v[inst]}, 32'd0);
            chk("ab_in_done", {30'd0, a_v[inst], b_v[inst]}, 32'd0);
         end else if (n < v.lat) begin
            chk("ab_seq", {30'd0, a_v[inst], b_v[inst]}, n / (v.s + 1));
            chk("busy_mid", {31'd0, busy_v[inst]}, 32'd1);
            chk("tt_hold_mid", {28'd0, tt_v[inst]}, {28'd0, prev_tt[inst]});
            chk("id_hold_mid", {29'd0, id_v[inst]}, {29'd0, prev_id[inst]});
         end
      end
      start_v[inst] = 1'b0;
      if (!got) chk("done_timeout", 32'd0, 32'd1);
      prev_tt[inst] = v.etab;
      prev_id[inst] = v.eid;
      if (v.poke) begin
         for (int n = 0; n < 2 * v.lat; n++) begin
            @(negedge clk);
            chk("no_extra_done", {31'd0, done_v[inst]}, 32'd0);
            chk("no_restart", {31'd0, busy_v[inst]}, 32'd0);
         end
      end
   endtask

   initial begin
      bit found;
      vec_t v;
      rst = 1'b1;
      start_v = 3'b000;
      for (int i = 0; i < 3; i++) begin
         gtab[i] = 4'b0000;
         prev_tt[i] = 4'd0;
         prev_id[i] = 3'd0;
      end

      //            inst s lat gate     etab     id    v     poke
      vecs[0] = '{0, 1, 8,  4'b1000, 4'b1000, 3'd2, 1'b1, 1'b0};
      vecs[1] = '{1, 0, 4,  4'b0011, 4'b0011, 3'd1, 1'b1, 1'b0};
      vecs[2] = '{1, 0, 4,  4'b1110, 4'b1110, 3'd3, 1'b1, 1'b0};
      vecs[3] = '{1, 0, 4,  4'b0111, 4'b0111, 3'd4, 1'b1, 1'b0};
      vecs[4] = '{1, 0, 4,  4'b0001, 4'b0001, 3'd5, 1'b1, 1'b0};
      vecs[5] = '{1, 0, 4,  4'b0110, 4'b0110, 3'd6, 1'b1, 1'b0};
      vecs[6] = '{1, 0, 4,  4'b1001, 4'b1001, 3'd7, 1'b1, 1'b0};
      vecs[7] = '{1, 0, 4,  4'b1000, 4'b1000, 3'd2, 1'b1, 1'b0};
      vecs[8] = '{2, 2, 12, 4'b1111, 4'b1111, 3'd0, 1'b0, 1'b1};
      vecs[9] = '{0, 1, 8,  4'b0110, 4'b0110, 3'd6, 1'b1, 1'b0};

      // Reset, then idle with start low.
      #1;
      for (int i = 0; i < 3; i++) chk_reset_state(i, "reset_state");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) chk_reset_state(i, "idle_state");
      end

      // Table-driven scans.
      for (int k = 0; k < 10; k++) begin
         gtab[vecs[k].inst] = vecs[k].gate;
         scan(vecs[k]);
      end

      // Reset in the middle of a scan while {A,B}=10.
      @(negedge clk);
      start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      found = 0;
      for (int n = 0; n < 20 && !found; n++) begin
         @(negedge clk);
         if ({a_v[0], b_v[0]} == 2'b10) found = 1;
      end
      chk("reach_ab10", {31'd0, found}, 32'd1);
      rst = 1'b1;
      #1;
      chk_reset_state(0, "midscan_reset");
      @(negedge clk);
      chk_reset_state(0, "midscan_reset_hold");
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         prev_tt[i] = 4'd0;
         prev_id[i] = 3'd0;
      end
      gtab[0] = 4'b0001;
      v = '{0, 1, 8, 4'b0001, 4'b0001, 3'd5, 1'b1, 1'b0};
      scan(v);

      // Back-to-back scans with start held high, OR gate, S=0.
      gtab[1] = 4'b1110;
      @(negedge clk);
      start_v[1] = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 22; n++) begin
         bit exp_done;
         @(negedge clk);
         exp_done = (n % 5 == 4);
         chk("b2b_done", {31'd0, done_v[1]}, {31'd0, exp_done});
         chk("b2b_busy", {31'd0, busy_v[1]}, {31'd0, !exp_done});
         chk("b2b_tt", {28'd0, tt_v[1]}, (n >= 4) ? 32'b1110 : {28'd0, prev_tt[1]});
         if (n < 21) @(posedge clk);
      end
      start_v[1] = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
